platform_collider: RTL and testbench
====================================

// Module: platform_collider
// PURPOSE
//  Counterpart to the dope character block: owns the per-stage platform table, answers "is dope standing on a platform" (grounded) from dope_x/dope_y/d_jump.
//  Also renders platforms into the pixel stream (plat_on/rgb_next) for the top-level colour mux.
//  Sits beside the dope block; grounded feeds its walk/jump/down FSM.
// PARAMETERS
//  N_PLAT     8        platform slots per stage (slot 0 = floor)
//  PLAT_RGB   12'h841  platform fill colour
//  HILITE_RGB 12'hfc6  top-row colour (PLAT_TOP_HILITE_EN only)
// PORTS
//  clk       in   1   system clock
//  reset     in   1   synchronous, active-low
//  stage     in   4   current stage; any change reloads the table
//  dope_x    in   10  dope right edge x (dope spans dope_x-2*D_W+1 .. dope_x)
//  dope_y    in   10  dope top y (dope spans dope_y .. dope_y+2*D_H-1)
//  d_jump    in   1   dope in jump state
//  pixel_x   in   10  scan position x
//  pixel_y   in   10  scan position y
//  video_on  in   1   visible area
//  grounded  out  1   dope feet resting on a platform top
//  plat_on   out  1   current pixel (1-cycle delayed) is platform
//  rgb_next  out  12  platform colour, 0 when not plat_on
//  busy      out  1   table load or scan in progress
// BEHAVIOUR
//  Reset values: state=LOAD, idx=0, grounded=1, plat_on=0, rgb_next=0, busy=1, table cleared.
//  Entry = {x_l, x_r, y_top}, 10b each; x_l==x_r==0 marks an empty slot, never matches.
//  FSM LOAD -> IDLE -> SCAN -> COMMIT -> IDLE.
//   LOAD: read platform_rom(stage, idx) 1/cycle, 1-cycle ROM latency; table write is idx-1.
//         Takes N_PLAT+1 cycles, then IDLE with last_xy invalidated, forcing a scan.
//   IDLE: if {dope_x,dope_y} != last_xy (or last_xy invalid), snapshot the pair into last_xy and go to SCAN.
//   SCAN: idx 0..N_PLAT-1, one entry/cycle, OR into hit accumulator; N_PLAT cycles.
//   COMMIT: grounded <= hit & ~d_jump; go to IDLE. Latency from position change to grounded = N_PLAT+2 cycles.
//  Hit rule, 11-bit unsigned compare (no underflow):
//   snap_y + 2*D_H == y_top  AND  snap_x >= x_l  AND  snap_x + 1 <= x_r + 2*D_W.
//  d_jump=1: grounded forced 0 on the next edge, regardless of state; COMMIT also masks with d_jump.
//  Stage change (stage != prev_stage): any state aborts to LOAD next edge; a partial scan never commits.
//   grounded=1 during LOAD, because dope respawns on the floor.
//  Reset mid-LOAD/SCAN: same as power-on reset.
//  busy = (state != IDLE).
//  Render: one registered stage.
//   plat_on <= video_on & any(pixel inside [x_l..x_r] x [y_top..y_top+PLAT_T-1]) over valid slots.
//   rgb_next <= plat_on_comb ? PLAT_RGB : 0.
//   Table rewrites during LOAD may glitch one frame; accepted.
// CONFIGURATION
//  PLAT_TOP_HILITE_EN defined: pixels with pixel_y==y_top use HILITE_RGB instead of PLAT_RGB.
//  Undefined: all platform pixels use PLAT_RGB; HILITE_RGB unused.
// STRUCTURE
//  platform_pkg: D_W=26, D_H=44, LE_B=13, RI_B=627, LO_B=467, PLAT_T=8, entry typedef, FSM state enum.
//  Sub-module platform_rom: (stage, idx) -> entry, registered output.
//   Stage 0 slot 0 = floor {LE_B, RI_B, 448}.
//  Top: FSM, table regfile, scan comparator, render comparator bank.
// TESTING
//  1. Release reset, stage=0 -> busy=1 for N_PLAT+1 cycles, then a scan; grounded stays 1 throughout.
//  2. Ground check, stage 0, dope (133,360): feet row 448 = floor top -> grounded=1 N_PLAT+2 cycles after busy falls.
//     dope_y=361 -> grounded=0 after N_PLAT+2 cycles.
//  3. Platform {200,300,300}, dope_y=212:
//     dope_x=200 -> 1; 199 -> 0; 351 -> 1; 352 -> 0.
//  4. Grounded dope, d_jump=1 -> grounded=0 on next edge; d_jump=0 with position unchanged -> stays 0 until next scan.
//  5. Stage 0->1 at SCAN idx 3 -> LOAD next edge, grounded=1, no commit from aborted scan; stage-1 table active after load.
//  6. Pixel (250,300) on platform, video_on=1 -> plat_on=1 next cycle, rgb_next=HILITE_RGB if macro set, else PLAT_RGB.
//     video_on=0 -> plat_on=0, rgb_next=0.

Source files
------------

// File: rtl/platform_pkg.sv
// platform_pkg: shared geometry constants, table entry layout, FSM states
// and the stand/cover tests used by the platform collider.
package platform_pkg;
  localparam int D_W = 26;
  localparam int D_H = 44;
  localparam int LE_B = 13;
  localparam int RI_B = 627;
  localparam int LO_B = 467;
  localparam int PLAT_T = 8;
  typedef struct packed {
    logic [9:0] x_l;
    logic [9:0] x_r;
    logic [9:0] y_top;
  } entry_t;
  typedef enum logic [1:0] {LOAD, IDLE, SCAN, COMMIT} state_t;
  function automatic logic valid(entry_t e);
    return e.x_l != '0 || e.x_r != '0;
  endfunction
  // 11-bit sums keep x/y + offset from wrapping
  function automatic logic stands(entry_t e, logic [9:0] x, logic [9:0] y);
    return valid(e) && ({1'b0, y} + 11'(2 * D_H) == {1'b0, e.y_top}) && x >= e.x_l &&
           ({1'b0, x} + 11'd1 <= {1'b0, e.x_r} + 11'(2 * D_W));
  endfunction
  function automatic logic covers(entry_t e, logic [9:0] px, logic [9:0] py);
    return valid(e) && px >= e.x_l && px <= e.x_r && py >= e.y_top &&
           {1'b0, py} <= {1'b0, e.y_top} + 11'(PLAT_T - 1);
  endfunction
endpackage

// File: rtl/platform_collider_if.sv
// platform_collider_if: dope position, scan position and collider results.
interface platform_collider_if;
  logic [3:0] stage;
  logic [9:0] dope_x;
  logic [9:0] dope_y;
  logic d_jump;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic video_on;
  logic grounded;
  logic plat_on;
  logic [11:0] rgb_next;
  logic busy;
  modport master(output stage, dope_x, dope_y, d_jump, pixel_x, pixel_y, video_on,
                 input grounded, plat_on, rgb_next, busy);
  modport slave(input stage, dope_x, dope_y, d_jump, pixel_x, pixel_y, video_on,
                output grounded, plat_on, rgb_next, busy);
endinterface

// File: rtl/platform_rom.sv
// platform_rom: per-stage platform layout, registered output; slot 0 is the floor.
module platform_rom import platform_pkg::*; #(
  parameter int N_PLAT = 8,
  parameter int IW = 4
) (
  input  logic clk,
  input  logic [3:0] stage,
  input  logic [IW-1:0] idx,
  output entry_t q
);
  entry_t d;
  always_comb begin
    d = '0;
    if (idx == '0) d = '{10'(LE_B), 10'(RI_B), 10'd448};
    else if (stage == 4'd0 && idx == IW'(1)) d = '{10'd200, 10'd300, 10'd300};
    else if (stage == 4'd0 && idx == IW'(2)) d = '{10'd420, 10'd560, 10'd380};
    else if (stage == 4'd1 && idx == IW'(1)) d = '{10'd400, 10'd500, 10'd200};
  end
  // entries past the slot count or below the play field read as empty
  always_ff @(posedge clk)
    q <= (int'(idx) < N_PLAT && int'(d.y_top) <= LO_B) ? d : '0;
endmodule

// File: rtl/platform_collider.sv
// platform_collider: platform table, grounded scan FSM and platform renderer.
// Define PLAT_TOP_HILITE_EN to paint each platform's top row in HILITE_RGB.
module platform_collider import platform_pkg::*; #(
  parameter int N_PLAT = 8,
  parameter logic [11:0] PLAT_RGB = 12'h841,
  parameter logic [11:0] HILITE_RGB = 12'hfc6
) (
  input logic clk,
  input logic reset,
  platform_collider_if.slave bus
);
  localparam int IW = $clog2(N_PLAT + 1);
  localparam int SW = $clog2(N_PLAT);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  entry_t tbl [N_PLAT];
  entry_t rom_q;
  logic [3:0] prev_stage;
  logic [19:0] last_xy;
  logic last_ok, hit, grounded, plat_on, on_c, top_c;
  logic [11:0] rgb_next;
  wire abort = bus.stage != prev_stage;
  wire moved = !last_ok || {bus.dope_x, bus.dope_y} != last_xy;
  platform_rom #(.N_PLAT(N_PLAT), .IW(IW)) u_rom (.clk(clk), .stage(bus.stage), .idx(idx), .q(rom_q));
  always_ff @(posedge clk)
    if (!reset) begin
      state <= LOAD;
      idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
    end
  always_comb begin
    state_n = state;
    idx_n = idx;
    if (abort) begin
      state_n = LOAD;
      idx_n = '0;
    end else if (state == LOAD) begin
      idx_n = int'(idx) == N_PLAT ? '0 : idx + 1'b1;
      state_n = int'(idx) == N_PLAT ? IDLE : LOAD;
    end else if (state == IDLE) begin
      idx_n = '0;
      state_n = moved ? SCAN : IDLE;
    end else if (state == SCAN) begin
      idx_n = idx + 1'b1;
      state_n = int'(idx) == N_PLAT - 1 ? COMMIT : SCAN;
    end else state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      for (int i = 0; i < N_PLAT; i++) tbl[i] <= '0;
      prev_stage <= bus.stage;
      last_xy <= '0;
      last_ok <= 1'b0;
      hit <= 1'b0;
      grounded <= 1'b1;
    end else begin
      prev_stage <= bus.stage;
      // ROM output lags idx by one cycle, so the slot being written is idx-1
      if (state == LOAD && idx != '0) tbl[SW'(idx - 1'b1)] <= rom_q;
      if (state == IDLE && moved) last_xy <= {bus.dope_x, bus.dope_y};
      last_ok <= (state == LOAD || abort) ? 1'b0 : (state == IDLE && moved) ? 1'b1 : last_ok;
      hit <= state == SCAN && (hit || stands(tbl[idx[SW-1:0]], last_xy[19:10], last_xy[9:0]));
      grounded <= bus.d_jump ? 1'b0 : (abort || state == LOAD) ? 1'b1 : state == COMMIT ? hit : grounded;
    end
  always_comb begin
    on_c = 1'b0;
    top_c = 1'b0;
    for (int i = 0; i < N_PLAT; i++)
      if (covers(tbl[i], bus.pixel_x, bus.pixel_y)) begin
        on_c = 1'b1;
`ifdef PLAT_TOP_HILITE_EN
        if (bus.pixel_y == tbl[i].y_top) top_c = 1'b1;
`endif
      end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      plat_on <= 1'b0;
      rgb_next <= '0;
    end else begin
      plat_on <= bus.video_on & on_c;
      rgb_next <= (bus.video_on & on_c) ? (top_c ? HILITE_RGB : PLAT_RGB) : '0;
    end
  assign bus.grounded = grounded;
  assign bus.plat_on = plat_on;
  assign bus.rgb_next = rgb_next;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_platform_collider.sv
// tb_platform_collider: directed stimulus; grounded results are scored by a
// monitor that pops one expectation each time busy falls.
module tb_platform_collider;
  localparam logic [11:0] PLAT_RGB = 12'h841;
`ifdef PLAT_TOP_HILITE_EN
  localparam logic [11:0] TOP_RGB = 12'hfc6;
`else
  localparam logic [11:0] TOP_RGB = 12'h841;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic exp_q [$];
  platform_collider_if bus();
  platform_collider dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  initial begin : monitor
    logic prev_b = 1'b1;
    logic e;
    forever begin
      @(negedge clk);
      if (prev_b && !bus.busy) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL grounded_evt: unexpected result grounded=%0b, none required", bus.grounded);
        end else begin
          e = exp_q.pop_front();
          check("grounded_evt", 32'(bus.grounded), 32'(e));
        end
      end
      prev_b = bus.busy;
    end
  end
  task automatic settle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      compared++;
      mismatched++;
      $display("FAIL settle: timeout, %0d results still pending, required 0", exp_q.size());
    end
  endtask
  task automatic move(logic [9:0] x, logic [9:0] y, logic g);
    @(negedge clk);
    bus.dope_x = x;
    bus.dope_y = y;
    exp_q.push_back(g);
    settle();
  endtask
  task automatic render(logic [9:0] px, logic [9:0] py, logic vo, logic on, logic [11:0] rgb);
    @(negedge clk);
    bus.pixel_x = px;
    bus.pixel_y = py;
    bus.video_on = vo;
    @(negedge clk);
    check("plat_on", 32'(bus.plat_on), 32'(on));
    check("rgb_next", 32'(bus.rgb_next), 32'(rgb));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic g_ok;
    bus.stage = 4'd0;
    bus.dope_x = 10'd133;
    bus.dope_y = 10'd360;
    bus.d_jump = 1'b0;
    bus.pixel_x = '0;
    bus.pixel_y = '0;
    bus.video_on = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_grounded", 32'(bus.grounded), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd1);
    check("reset_plat_on", 32'(bus.plat_on), 32'd0);
    check("reset_rgb", 32'(bus.rgb_next), 32'd0);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    reset = 1'b1;
    n = 0;
    g_ok = 1'b1;
    while (bus.busy && n < 50) begin
      n++;
      g_ok &= bus.grounded;
      @(negedge clk);
    end
    check("load_cycles", 32'(n), 32'd9);
    check("load_grounded", 32'(g_ok), 32'd1);
    settle();
    @(negedge clk);
    bus.dope_y = 10'd361;
    exp_q.push_back(1'b0);
    n = 0;
    while (bus.grounded && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ground_latency", 32'(n), 32'd10);
    settle();
    move(10'd200, 10'd212, 1'b1);
    move(10'd199, 10'd212, 1'b0);
    move(10'd351, 10'd212, 1'b1);
    move(10'd352, 10'd212, 1'b0);
    move(10'd201, 10'd212, 1'b1);
    @(negedge clk);
    bus.d_jump = 1'b1;
    @(negedge clk);
    check("jump_grounded", 32'(bus.grounded), 32'd0);
    bus.d_jump = 1'b0;
    repeat (3) @(negedge clk);
    check("jump_hold", 32'(bus.grounded), 32'd0);
    check("jump_no_scan", 32'(bus.busy), 32'd0);
    move(10'd200, 10'd212, 1'b1);
    render(10'd250, 10'd300, 1'b1, 1'b1, TOP_RGB);
    render(10'd250, 10'd303, 1'b1, 1'b1, PLAT_RGB);
    render(10'd300, 10'd307, 1'b1, 1'b1, PLAT_RGB);
    render(10'd250, 10'd308, 1'b1, 1'b0, 12'h000);
    render(10'd199, 10'd300, 1'b1, 1'b0, 12'h000);
    render(10'd13, 10'd448, 1'b1, 1'b1, TOP_RGB);
    render(10'd250, 10'd300, 1'b0, 1'b0, 12'h000);
    move(10'd199, 10'd212, 1'b0);
    @(negedge clk);
    bus.dope_x = 10'd133;
    bus.dope_y = 10'd360;
    repeat (4) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    bus.stage = 4'd1;
    @(negedge clk);
    check("abort_grounded", 32'(bus.grounded), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd1);
    settle();
    move(10'd420, 10'd112, 1'b1);
    move(10'd250, 10'd212, 1'b0);
    render(10'd450, 10'd204, 1'b1, 1'b1, PLAT_RGB);
    render(10'd250, 10'd300, 1'b1, 1'b0, 12'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
